// File: rtl/boot_loader_46_pkg.sv
// Shared loader definitions: FSM state encodings and frame layout constants.
// Pure declarations, no logic.
package boot_loader_46_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader_46_byte_assembler.sv
// Little-endian word assembler with running XOR; word/word_full are combinational on the accepted byte.
// No backpressure of its own: the caller gates accept with the link handshake.
module byte_assembler_46
    import boot_loader_46_pkg::*;
(
    input  logic        clk_46,
    input  logic        rst_46,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word,
    output logic        word_full,
    output logic [7:0]  xor_acc
);

    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    // The byte completing a word is merged here so the write can launch on its handshake edge.
    always_comb begin
        word = word_q;
        word[{idx_q, 3'b000} +: 8] = byte_dat;
    end

    assign word_full = accept && (idx_q == IDX_LAST);

    always_ff @(posedge clk_46 or negedge rst_46) begin
        if (!rst_46) begin
            idx_q   <= 2'd0;
            word_q  <= 32'h0;
            xor_acc <= 8'h00;
        end else if (clear) begin
            idx_q   <= 2'd0;
            word_q  <= 32'h0;
            xor_acc <= 8'h00;
        end else if (accept) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_dat;
            idx_q   <= idx_q + 2'd1;
            xor_acc <= xor_acc ^ byte_dat;
        end
    end

endmodule

// File: rtl/boot_loader_46.sv
// Byte-stream program loader: writes 32-bit words to instruction memory one cycle after each 4th byte, then releases proc reset on a good XOR checksum.
// byte_ready drops for the single write cycle and outside an active load; the source holds its byte meanwhile.
module boot_loader_46 #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk_46,
    input  logic        rst_46,
    input  logic        start_46,
    input  logic [7:0]  byte_data_46,
    input  logic        byte_valid_46,
    output logic        byte_ready_46,
    output logic [31:0] mwa_i_46,
    output logic [31:0] mwd_i_46,
    output logic        mwr_i_46,
    output logic        proc_rst_46,
    output logic        done_46,
    output logic        err_46,
    output logic [15:0] words_loaded_46
);
    import boot_loader_46_pkg::*;

    localparam logic [31:0] ADDR_STEP_W = ADDR_STEP[31:0];

    state_t      state_q, state_d;
    logic        ready_d, mwr_d, proc_rst_d, done_d, err_d;
    logic [31:0] mwa_d, mwd_d;
    logic [15:0] words_d, len_q, len_d;
    logic        fire, asm_clear, asm_accept, word_full;
    logic [31:0] word;
    logic [7:0]  xor_acc;
    logic [15:0] len_new, words_inc;

    assign fire      = byte_valid_46 && byte_ready_46;
    assign len_new   = {byte_data_46, len_q[7:0]};
    assign words_inc = words_loaded_46 + 16'd1;

    byte_assembler_46 u_asm (
        .clk_46    (clk_46),
        .rst_46    (rst_46),
        .clear     (asm_clear),
        .accept    (asm_accept),
        .byte_dat  (byte_data_46),
        .word      (word),
        .word_full (word_full),
        .xor_acc   (xor_acc)
    );

    always_comb begin
        state_d    = state_q;
        ready_d    = byte_ready_46;
        mwa_d      = mwa_i_46;
        mwd_d      = mwd_i_46;
        mwr_d      = 1'b0;
        proc_rst_d = proc_rst_46;
        done_d     = done_46;
        err_d      = err_46;
        words_d    = words_loaded_46;
        len_d      = len_q;
        asm_clear  = 1'b0;
        asm_accept = 1'b0;

        case (state_q)
            ST_LEN_LO: begin
                if (fire) begin
                    len_d   = {8'h00, byte_data_46};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (fire) begin
                    len_d = len_new;
                    if ((len_new == 16'd0) || ({16'h0000, len_new} > MAX_WORDS)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                asm_accept = fire;
                if (word_full) begin
                    state_d = ST_WRITE;
                    ready_d = 1'b0;
                    mwr_d   = 1'b1;
                    mwa_d   = BASE_ADDR + ADDR_STEP_W * {16'h0000, words_loaded_46};
                    mwd_d   = word;
                end
            end
            ST_WRITE: begin
                words_d = words_inc;
                ready_d = 1'b1;
                state_d = (words_inc == len_q) ? ST_CHK : ST_DATA;
            end
            ST_CHK: begin
                if (fire) begin
                    ready_d = 1'b0;
                    if (byte_data_46 == xor_acc) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        proc_rst_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_46) begin
                    state_d    = ST_LEN_LO;
                    ready_d    = 1'b1;
                    words_d    = 16'd0;
                    len_d      = 16'd0;
                    asm_clear  = 1'b1;
                    proc_rst_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_46 or negedge rst_46) begin
        if (!rst_46) begin
            state_q         <= ST_IDLE;
            byte_ready_46   <= 1'b0;
            mwa_i_46        <= 32'h0;
            mwd_i_46        <= 32'h0;
            mwr_i_46        <= 1'b0;
            proc_rst_46     <= 1'b1;
            done_46         <= 1'b0;
            err_46          <= 1'b0;
            words_loaded_46 <= 16'd0;
            len_q           <= 16'd0;
        end else begin
            state_q         <= state_d;
            byte_ready_46   <= ready_d;
            mwa_i_46        <= mwa_d;
            mwd_i_46        <= mwd_d;
            mwr_i_46        <= mwr_d;
            proc_rst_46     <= proc_rst_d;
            done_46         <= done_d;
            err_46          <= err_d;
            words_loaded_46 <= words_d;
            len_q           <= len_d;
        end
    end

endmodule

// File: tb/tb_boot_loader_46.sv
// Bench for boot_loader_46: byte-count frame model checked every cycle, plus literal expectations per scenario.
module tb_boot_loader_46;

    localparam int MAXW = 256;

    logic        clk_46 = 1'b0;
    logic        rst_46 = 1'b0;
    logic        start_46 = 1'b0;
    logic [7:0]  byte_data_46 = 8'h00;
    logic        byte_valid_46 = 1'b0;
    logic        byte_ready_46;
    logic [31:0] mwa_i_46, mwd_i_46;
    logic        mwr_i_46, proc_rst_46, done_46, err_46;
    logic [15:0] words_loaded_46;

    boot_loader_46 dut (
        .clk_46          (clk_46),
        .rst_46          (rst_46),
        .start_46        (start_46),
        .byte_data_46    (byte_data_46),
        .byte_valid_46   (byte_valid_46),
        .byte_ready_46   (byte_ready_46),
        .mwa_i_46        (mwa_i_46),
        .mwd_i_46        (mwd_i_46),
        .mwr_i_46        (mwr_i_46),
        .proc_rst_46     (proc_rst_46),
        .done_46         (done_46),
        .err_46          (err_46),
        .words_loaded_46 (words_loaded_46)
    );

    always #5 clk_46 = ~clk_46;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected output values after the upcoming clock edge, derived from frame byte counts.
    logic        exp_ready = 1'b0, exp_mwr = 1'b0, exp_prst = 1'b1, exp_done = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_mwa = 32'h0, exp_mwd = 32'h0;
    int          exp_words = 0;
    bit          m_busy = 1'b0;
    int          m_fires = 0, m_len = 0;
    logic [31:0] m_word = 32'h0;
    logic [7:0]  m_xor = 8'h00;
    logic [31:0] log_a[$], log_d[$];

    always @(negedge clk_46) begin
        if (!rst_46) begin
            exp_ready = 0; exp_mwr = 0; exp_prst = 1; exp_done = 0; exp_err = 0;
            exp_words = 0; m_busy = 0; m_fires = 0;
        end
        chk("ready", 32'(byte_ready_46), 32'(exp_ready));
        chk("mwr", 32'(mwr_i_46), 32'(exp_mwr));
        chk("proc_rst", 32'(proc_rst_46), 32'(exp_prst));
        chk("done", 32'(done_46), 32'(exp_done));
        chk("err", 32'(err_46), 32'(exp_err));
        chk("words_loaded", 32'(words_loaded_46), 32'(exp_words));
        if (exp_mwr) begin
            chk("mwa", mwa_i_46, exp_mwa);
            chk("mwd", mwd_i_46, exp_mwd);
        end
        if (mwr_i_46) begin
            log_a.push_back(mwa_i_46);
            log_d.push_back(mwd_i_46);
        end
        if (rst_46) begin
            if (exp_mwr) begin
                exp_words++;
                exp_ready = 1;
            end
            exp_mwr = 0;
            if (start_46 && !m_busy) begin
                m_busy = 1; m_fires = 0; m_xor = 8'h00; m_len = 0;
                exp_ready = 1; exp_words = 0; exp_done = 0; exp_err = 0; exp_prst = 1;
            end
            if (byte_valid_46 && byte_ready_46 && m_busy) begin
                m_fires++;
                if (m_fires == 1) begin
                    m_len = int'(byte_data_46);
                end else if (m_fires == 2) begin
                    m_len += 256 * int'(byte_data_46);
                    if (m_len == 0 || m_len > MAXW) begin
                        exp_err = 1; exp_ready = 0; m_busy = 0;
                    end
                end else if (m_fires <= 2 + 4 * m_len) begin
                    int d;
                    d = m_fires - 3;
                    m_word[8 * (d % 4) +: 8] = byte_data_46;
                    m_xor ^= byte_data_46;
                    if (d % 4 == 3) begin
                        exp_mwr = 1; exp_ready = 0;
                        exp_mwa = 32'(4 * (d / 4));
                        exp_mwd = m_word;
                    end
                end else begin
                    if (byte_data_46 == m_xor) begin
                        exp_done = 1; exp_prst = 0;
                    end else begin
                        exp_err = 1;
                    end
                    exp_ready = 0; m_busy = 0;
                end
            end
        end
    end

    logic [7:0] frame[$];
    int sent;

    task automatic build_frame(input int n, input bit rnd, input bit bad);
        logic [31:0] w;
        logic [7:0]  x;
        frame.delete();
        x = 8'h00;
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            if (rnd) w = $urandom;
            else     w = (i == 0) ? 32'h2001_0005 : 32'h2002_0003;
            for (int b = 0; b < 4; b++) begin
                frame.push_back(w[8*b +: 8]);
                x ^= w[8*b +: 8];
            end
        end
        frame.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    // Returns after the accepting edge of each byte; stops early if the DUT never takes one.
    task automatic send_bytes(input bit gaps, input int budget, output int nsent);
        nsent = 0;
        foreach (frame[i]) begin
            int  waited;
            bit  ok;
            waited = 0; ok = 0;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    byte_valid_46 = 0;
                    @(posedge clk_46); #1;
                end
            end
            byte_data_46 = frame[i];
            byte_valid_46 = 1;
            while (!ok && waited < budget) begin
                @(negedge clk_46);
                if (byte_ready_46) ok = 1;
                else waited++;
                @(posedge clk_46); #1;
            end
            if (!ok) begin
                byte_valid_46 = 0;
                return;
            end
            nsent++;
        end
        byte_valid_46 = 0;
    endtask

    task automatic pulse_start();
        start_46 = 1;
        @(posedge clk_46); #1;
        start_46 = 0;
    endtask

    task automatic chk_good_log(input string tag);
        chk({tag, "_nwrites"}, 32'(log_a.size()), 32'd2);
        if (log_a.size() == 2) begin
            chk({tag, "_a0"}, log_a[0], 32'h0);
            chk({tag, "_d0"}, log_d[0], 32'h2001_0005);
            chk({tag, "_a1"}, log_a[1], 32'h4);
            chk({tag, "_d1"}, log_d[1], 32'h2002_0003);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_46);
        #1;
        chk("rst_proc_rst", 32'(proc_rst_46), 32'd1);
        chk("rst_ready", 32'(byte_ready_46), 32'd0);
        rst_46 = 1;
        @(posedge clk_46); #1;

        // Good frame, back-to-back bytes: next byte is held valid during each write cycle.
        log_a.delete(); log_d.delete();
        pulse_start();
        build_frame(2, 0, 0);
        send_bytes(0, 20, sent);
        chk("t1_sent", 32'(sent), 32'(frame.size()));
        chk("t1_done", 32'(done_46), 32'd1);
        chk("t1_proc_rst", 32'(proc_rst_46), 32'd0);
        chk("t1_words", 32'(words_loaded_46), 32'd2);
        chk_good_log("t1");

        // Start from DONE, then bad checksum.
        log_a.delete(); log_d.delete();
        pulse_start();
        chk("t2_restart_prst", 32'(proc_rst_46), 32'd1);
        chk("t2_restart_done", 32'(done_46), 32'd0);
        build_frame(2, 0, 1);
        send_bytes(0, 20, sent);
        chk("t2_sent", 32'(sent), 32'(frame.size()));
        chk("t2_err", 32'(err_46), 32'd1);
        chk("t2_done", 32'(done_46), 32'd0);
        chk("t2_proc_rst", 32'(proc_rst_46), 32'd1);
        chk_good_log("t2");

        // Illegal lengths: zero and 257.
        for (int t = 0; t < 2; t++) begin
            log_a.delete(); log_d.delete();
            pulse_start();
            frame.delete();
            frame.push_back(t == 0 ? 8'h00 : 8'h01);
            frame.push_back(t == 0 ? 8'h00 : 8'h01);
            frame.push_back(8'hAA);
            send_bytes(0, 8, sent);
            chk("t3_sent", 32'(sent), 32'd2);
            chk("t3_err", 32'(err_46), 32'd1);
            chk("t3_nwrites", 32'(log_a.size()), 32'd0);
            chk("t3_words", 32'(words_loaded_46), 32'd0);
        end

        // Good frame with random valid gaps.
        log_a.delete(); log_d.delete();
        pulse_start();
        build_frame(2, 0, 0);
        send_bytes(1, 20, sent);
        chk("t4_done", 32'(done_46), 32'd1);
        chk_good_log("t4");

        // Reset after 6 data bytes, then full reload.
        pulse_start();
        build_frame(2, 0, 0);
        frame = frame[0:7];
        send_bytes(0, 20, sent);
        chk("t5_partial_sent", 32'(sent), 32'd8);
        @(posedge clk_46); #3;
        rst_46 = 0;
        #1;
        chk("t5_ready", 32'(byte_ready_46), 32'd0);
        chk("t5_mwa", mwa_i_46, 32'h0);
        chk("t5_mwd", mwd_i_46, 32'h0);
        chk("t5_prst", 32'(proc_rst_46), 32'd1);
        chk("t5_words", 32'(words_loaded_46), 32'd0);
        @(posedge clk_46); #1;
        rst_46 = 1;
        @(posedge clk_46); #1;
        log_a.delete(); log_d.delete();
        pulse_start();
        build_frame(2, 0, 0);
        send_bytes(0, 20, sent);
        chk("t5_done", 32'(done_46), 32'd1);
        chk_good_log("t5");

        // Start pulse in the middle of DATA must be ignored.
        log_a.delete(); log_d.delete();
        pulse_start();
        build_frame(2, 0, 0);
        fork
            send_bytes(0, 20, sent);
            begin
                repeat (5) @(posedge clk_46);
                #1;
                start_46 = 1;
                @(posedge clk_46); #1;
                start_46 = 0;
            end
        join
        chk("t6_done", 32'(done_46), 32'd1);
        chk_good_log("t6");

        // Random frames; the last is the maximum legal length.
        for (int r = 0; r < 6; r++) begin
            int n;
            bit bad;
            n   = (r == 5) ? MAXW : int'($urandom_range(1, 5));
            bad = (r == 5) ? 1'b0 : 1'($urandom_range(0, 1));
            pulse_start();
            build_frame(n, 1, bad);
            send_bytes(1, 30, sent);
            chk("rnd_sent", 32'(sent), 32'(frame.size()));
            chk("rnd_done", 32'(done_46), 32'(!bad));
            chk("rnd_err", 32'(err_46), 32'(bad));
            chk("rnd_words", 32'(words_loaded_46), 32'(n));
        end

        repeat (3) @(posedge clk_46);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/boot_loader_46.md
Name: boot_loader_46

Overview:
- Program loader sitting directly upstream of ins_mem_46 and proc.
- Receives a byte stream over a valid/ready link, assembles 32-bit little-endian instruction words and writes them into instruction memory through the mwa_i/mwd_i/mwr_i write port.
- Validates an XOR checksum, then releases the processor's active-high reset so proc starts fetching the loaded program.

Parameters:
- MAX_WORDS, 256, largest accepted program length in words (at most 65535).
- BASE_ADDR, 32'h0000_0000, address of word 0.
- ADDR_STEP, 4, address increment per word (byte-addressed PC).

Ports:
- clk_46  in  1  clock, rising edge.
- rst_46  in  1  reset; asynchronous, active-low.
- start_46  in  1  single-cycle pulse; begins a load.
- byte_data_46  in  8  stream byte.
- byte_valid_46  in  1  byte_data_46 is valid.
- byte_ready_46  out  1  loader accepts a byte this cycle.
- mwa_i_46  out  32  instruction memory write address.
- mwd_i_46  out  32  instruction memory write data.
- mwr_i_46  out  1  instruction memory write strobe.
- proc_rst_46  out  1  active-high reset to proc.
- done_46  out  1  load completed with good checksum.
- err_46  out  1  load failed.
- words_loaded_46  out  16  count of words written in the current load.

Behaviour:
- All outputs are registered. Reset values: byte_ready 0, mwa 0, mwd 0, mwr 0, proc_rst 1, done 0, err 0, words_loaded 0, state IDLE.
- A byte is accepted only on a cycle with byte_valid & byte_ready. Valid bytes offered while ready=0 are not consumed; the source must hold them.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N data bytes (first byte goes to word[7:0]), then 1 checksum byte. The checksum is the XOR of the 4N data bytes only; the length bytes are excluded.
- IDLE: ready 0. start -> LEN_LO, with ready 1, words_loaded 0, running XOR 0, proc_rst 1.
- LEN_LO: accept byte -> LEN_HI.
- LEN_HI: accept byte. If N==0 or N>MAX_WORDS -> ERR; else -> DATA.
- DATA: accept 4 bytes using a 2-bit index. The 4th accepted byte -> WRITE, and ready deasserts the following cycle.
- WRITE: exactly one cycle with mwr=1, mwa=BASE_ADDR+ADDR_STEP*k (32-bit wrap), mwd=assembled word. Write latency is one cycle after the 4th byte's handshake. words_loaded increments at the end of WRITE. Then -> CHK if k+1==N, else -> DATA with ready 1.
- mwa and mwd hold their last value after the write; mwr returns to 0.
- CHK: accept 1 byte. Equal to running XOR -> DONE, else -> ERR.
- DONE: done 1, ready 0, proc_rst 0.
- ERR: err 1, ready 0, proc_rst 1. Words already written stay in memory.
- start is ignored in LEN_LO..CHK. start in DONE or ERR clears done/err, reasserts proc_rst and goes to LEN_LO.
- Asynchronous reset at any point returns all outputs to reset values immediately. A partial load is abandoned; memory contents are not cleared.

Decomposition:
- Shared include file boot_loader_defs_46.v: state encodings (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR) and frame constants (header bytes=2, bytes per word=4).
- One sub-module, byte_assembler_46: 2-bit byte index, 32-bit little-endian shift/placement, running XOR. Controls: clear, accept. Outputs: word, word_full, xor_acc.

Test Plan:
- Frame N=2, bytes 05 00 01 20 03 00 02 20, checksum 05 -> writes (0x0,0x20010005) and (0x4,0x20020003); done=1; proc_rst falls 1 cycle after checksum accept; words_loaded=2.
- Same frame with checksum 06 -> both writes occur; err=1; proc_rst stays 1; done=0.
- Length 00 00, and separately length 01 01 (257 > MAX_WORDS) -> err=1 after LEN_HI, no mwr pulse, no further bytes accepted.
- Good frame with byte_valid randomly deasserted and a byte held valid during WRITE -> held byte is not consumed while ready=0; memory contents identical to test 1.
- Reset asserted low after 6 data bytes, then start plus the full good frame -> outputs reset immediately; reload writes addresses 0 and 4 correctly; done=1.
- start pulsed mid-DATA -> ignored. start in DONE -> proc_rst=1, done=0, new load accepted.
